// File: rtl/w5300_irq_handler_pkg.sv
// Shared definitions for the W5300 interrupt handler: register map, interrupt
// bit masks, socket numbering and the handler FSM state type.
package w5300_irq_handler_pkg;

   localparam logic [9:0] IR_ADDR      = 10'h002;
   localparam logic [9:0] SN_IR_BASE   = 10'h206;
   localparam logic [9:0] SN_IR_STRIDE = 10'h040;

   localparam logic [15:0] IR_IMR_IPCF    = 16'h8000;
   localparam logic [15:0] IR_IMR_DPUR    = 16'h4000;
   localparam logic [15:0] IR_IMR_UNREACH = 16'h2000;
   localparam logic [15:0] IR_IMR_FMTU    = 16'h1000;

   localparam logic [7:0] SN_IR_IMR_CONNECT = 8'h01;
   localparam logic [7:0] SN_IR_IMR_DISCON  = 8'h02;
   localparam logic [7:0] SN_IR_IMR_RECV    = 8'h04;
   localparam logic [7:0] SN_IR_IMR_TIMEOUT = 8'h08;
   localparam logic [7:0] SN_IR_IMR_SENDOK  = 8'h10;

   typedef enum logic [2:0] {
      Socket0 = 3'd0, Socket1 = 3'd1, Socket2 = 3'd2, Socket3 = 3'd3,
      Socket4 = 3'd4, Socket5 = 3'd5, Socket6 = 3'd6, Socket7 = 3'd7
   } socket_e;

   typedef enum logic [3:0] {
      IDLE, RD_IR, LAT_IR, WR_IR, RPT_IR, SCAN, RD_SN, LAT_SN, WR_SN, RPT_SN
   } state_e;

   // Index of the lowest set bit; sockets are serviced from 0 upward.
   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

   function automatic logic [9:0] sn_ir_addr(input socket_e n);
      sn_ir_addr = SN_IR_BASE + SN_IR_STRIDE * {7'd0, n};
   endfunction

endpackage

// File: rtl/w5300_int_sync.sv
// Two-flop synchronizer for the W5300 INTn pin; resets to the inactive (high)
// level so no interrupt is seen while coming out of reset.
module w5300_int_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta     <= 1'b1;
         sync_out <= 1'b1;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/w5300_irq_handler.sv
// W5300 INTn service engine: reads IR, acknowledges and reports common bits,
// then reads/acknowledges/reports Sn_IR per flagged socket. IRQ_SYNC_EN adds
// a 2-flop synchronizer on int_n.
module w5300_irq_handler
   import w5300_irq_handler_pkg::*;
#(
   parameter int         NUM_SOCKETS = 8,
   parameter logic [9:0] IDLE_ADDR   = 10'h3FF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        int_n,
   input  logic        op_state,
   input  logic [15:0] rd_data,
   output logic [10:0] addr,
   output logic [15:0] wr_data,
   output logic [7:0]  ir_state,
   output logic [3:0]  socket,
   output logic        clear
);

   localparam int unsigned SOCK_MASK_INT = (1 << NUM_SOCKETS) - 1;
   localparam logic [7:0]  SOCK_MASK     = SOCK_MASK_INT[7:0];

   state_e      state, state_nx;
   logic        int_s;
   logic [7:0]  ir_common;
   logic [7:0]  pend;
   logic [7:0]  sn_reg;
   socket_e     cur_sock;
   logic [15:0] wr_data_hold;

`ifdef IRQ_SYNC_EN
   w5300_int_sync u_int_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (int_n),
      .sync_out (int_s)
   );
`else
   assign int_s = int_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Access states drive the bus and wait for op_state; LAT_IR decides the
   // branch straight from rd_data since it is valid in that cycle.
   always_comb begin
      state_nx = state;
      addr     = {1'b0, IDLE_ADDR};
      wr_data  = wr_data_hold;
      clear    = 1'b0;
      case (state)
         IDLE:    if (!int_s) state_nx = RD_IR;
         RD_IR: begin
            addr = {1'b0, IR_ADDR};
            if (op_state) state_nx = LAT_IR;
         end
         LAT_IR: begin
            if (rd_data[15:8] != 8'h00)                   state_nx = WR_IR;
            else if ((rd_data[7:0] & SOCK_MASK) != 8'h00) state_nx = SCAN;
            else                                          state_nx = IDLE;
         end
         WR_IR: begin
            addr    = {1'b1, IR_ADDR};
            wr_data = {ir_common, 8'h00};
            if (op_state) state_nx = RPT_IR;
         end
         RPT_IR: begin
            clear    = 1'b1;
            state_nx = SCAN;
         end
         SCAN:    state_nx = (pend != 8'h00) ? RD_SN : IDLE;
         RD_SN: begin
            addr = {1'b0, sn_ir_addr(cur_sock)};
            if (op_state) state_nx = LAT_SN;
         end
         LAT_SN:  state_nx = WR_SN;
         WR_SN: begin
            addr    = {1'b1, sn_ir_addr(cur_sock)};
            wr_data = {8'h00, sn_reg};
            if (op_state) state_nx = RPT_SN;
         end
         RPT_SN: begin
            clear    = 1'b1;
            state_nx = SCAN;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Report registers load on the accepted acknowledge write so they are
   // already valid during the clear strobe and hold until the next report.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_common    <= 8'h00;
         pend         <= 8'h00;
         sn_reg       <= 8'h00;
         cur_sock     <= Socket0;
         wr_data_hold <= 16'h0000;
         ir_state     <= 8'h00;
         socket       <= 4'b0000;
      end else begin
         wr_data_hold <= wr_data;
         if (state == LAT_IR) begin
            ir_common <= rd_data[15:8];
            pend      <= rd_data[7:0] & SOCK_MASK;
         end
         if (state == SCAN && pend != 8'h00) begin
            cur_sock <= socket_e'(lowest_set(pend));
            pend     <= pend & ~(8'h01 << lowest_set(pend));
         end
         if (state == LAT_SN) sn_reg <= rd_data[7:0];
         if (state == WR_IR && op_state) begin
            ir_state <= ir_common;
            socket   <= 4'b0000;
         end
         if (state == WR_SN && op_state) begin
            ir_state <= sn_reg;
            socket   <= {1'b1, cur_sock};
         end
      end
   end

endmodule

// File: tb/tb_w5300_irq_handler.sv
// Bench for w5300_irq_handler: acts as the W5300 register file and bus engine,
// and checks every accepted access and report against a transaction model.
module tb_w5300_irq_handler;

   localparam logic [10:0] IDLE_A = {1'b0, 10'h3FF};

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        int_n = 1'b1;
   logic        op_state = 1'b0;
   logic [15:0] rd_data = 16'h0000;
   logic [10:0] addr;
   logic [15:0] wr_data;
   logic [7:0]  ir_state;
   logic [3:0]  socket;
   logic        clear;

   w5300_irq_handler dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .int_n    (int_n),
      .op_state (op_state),
      .rd_data  (rd_data),
      .addr     (addr),
      .wr_data  (wr_data),
      .ir_state (ir_state),
      .socket   (socket),
      .clear    (clear)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         kind;
      logic [10:0] a;
      logic [15:0] d;
      logic [7:0]  irs;
      logic [3:0]  sk;
      int          n;
      bit          is_ir;
   } item_t;

   item_t       exp_q[$];
   logic [15:0] ir_mem = 16'h0000;
   logic [7:0]  sn_mem [8];
   bit          force_low = 0, inject_en = 0, irq_seen = 0, pend_rd = 0, prev_stall = 0;
   logic [15:0] pend_val, prev_wd, last_wd;
   logic [10:0] prev_addr;
   logic [7:0]  last_irs;
   logic [3:0]  last_sk;
   int          op_mode = 1;
   int          compared = 0, mismatched = 0;
   logic [10:0] log_a[$];
   logic [15:0] log_d[$];
   logic [7:0]  ev_irs[$];
   logic [3:0]  ev_sk[$];

   function automatic logic [9:0] sn_addr(input int n);
      sn_addr = 10'h206 + 10'h040 * 10'(n);
   endfunction

   function automatic item_t mk(input int kind, input logic [10:0] a, input logic [15:0] d,
                                input logic [7:0] irs, input logic [3:0] sk, input int n,
                                input bit is_ir);
      mk = '{kind: kind, a: a, d: d, irs: irs, sk: sk, n: n, is_ir: is_ir};
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply_stimulus(input logic [7:0] common, input int n, input logic [7:0] val);
      ir_mem[15:8] = ir_mem[15:8] | common;
      if (val != 8'h00) begin
         sn_mem[n] = sn_mem[n] | val;
         ir_mem[n] = 1'b1;
      end
   endtask

   task automatic inject();
      if ($urandom_range(0, 3) == 0) ir_mem[15:8] = ir_mem[15:8] | 8'(1 << $urandom_range(0, 7));
      else apply_stimulus(8'h00, $urandom_range(0, 7), 8'($urandom_range(1, 31)));
   endtask

   // An IR read opens a service pass: common ack/report, then one Sn_IR read
   // per flagged socket; each Sn_IR read expands into its own ack and report.
   task automatic handle_access();
      item_t      it;
      logic [7:0] v;
      log_a.push_back(addr);
      log_d.push_back(wr_data);
      if (addr == {1'b0, 10'h002}) begin
         check_output("ir read queue empty", exp_q.size(), 0);
         check_output("ir read cause", irq_seen, 1);
         irq_seen  = 0;
         force_low = 0;
         pend_rd   = 1;
         pend_val  = ir_mem;
         if (ir_mem[15:8] != 8'h00) begin
            exp_q.push_back(mk(1, {1'b1, 10'h002}, {ir_mem[15:8], 8'h00}, 8'h00, 4'h0, 0, 1));
            exp_q.push_back(mk(2, 11'h0, 16'h0, ir_mem[15:8], 4'b0000, 0, 1));
         end
         for (int n = 0; n < 8; n++)
            if (ir_mem[n]) exp_q.push_back(mk(0, {1'b0, sn_addr(n)}, 16'h0, 8'h00, 4'h0, n, 0));
      end else begin
         check_output("access expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) begin
            it = exp_q.pop_front();
            check_output("access kind", {31'd0, addr[10]}, it.kind);
            check_output("access addr", addr, it.a);
            if (it.kind == 1) begin
               check_output("ack wr_data", wr_data, it.d);
               if (it.is_ir) ir_mem[15:8] = ir_mem[15:8] & ~wr_data[15:8];
               else begin
                  sn_mem[it.n] = sn_mem[it.n] & ~wr_data[7:0];
                  if (sn_mem[it.n] == 8'h00) ir_mem[it.n] = 1'b0;
               end
            end else if (it.kind == 0) begin
               v        = sn_mem[it.n];
               pend_rd  = 1;
               pend_val = {8'h00, v};
               exp_q.push_front(mk(2, 11'h0, 16'h0, v, {1'b1, 3'(it.n)}, it.n, 0));
               exp_q.push_front(mk(1, {1'b1, sn_addr(it.n)}, {8'h00, v}, 8'h00, 4'h0, it.n, 0));
            end
         end
      end
   endtask

   always @(negedge clk) begin
      int_n = !((ir_mem != 16'h0000) || force_low);
      if (!int_n && exp_q.size() == 0) irq_seen = 1;
      if (!rst_n) begin
         check_output("reset addr", addr, IDLE_A);
         check_output("reset wr_data", wr_data, 16'h0000);
         check_output("reset ir_state", ir_state, 8'h00);
         check_output("reset socket", socket, 4'h0);
         check_output("reset clear", clear, 0);
         exp_q.delete();
         last_irs = 8'h00; last_sk = 4'h0; last_wd = 16'h0000;
         pend_rd = 0; prev_stall = 0; op_state = 0;
         rd_data = 16'($urandom);
      end else begin
         rd_data = pend_rd ? pend_val : 16'($urandom);
         pend_rd = 0;
         if (prev_stall) begin
            check_output("stall addr held", addr, prev_addr);
            check_output("stall wr_data held", wr_data, prev_wd);
         end
         if (clear) begin
            check_output("report expected", (exp_q.size() != 0) && (exp_q[0].kind == 2), 1);
            if (exp_q.size() != 0 && exp_q[0].kind == 2) begin
               check_output("report ir_state", ir_state, exp_q[0].irs);
               check_output("report socket", socket, exp_q[0].sk);
               last_irs = exp_q[0].irs;
               last_sk  = exp_q[0].sk;
               ev_irs.push_back(ir_state);
               ev_sk.push_back(socket);
               void'(exp_q.pop_front());
            end
         end else begin
            check_output("ir_state held", ir_state, last_irs);
            check_output("socket held", socket, last_sk);
         end
         if (addr[10]) last_wd = wr_data;
         else check_output("wr_data held", wr_data, last_wd);
         if (inject_en && $urandom_range(0, 99) < 3) inject();
         case (op_mode)
            1:       op_state = 1'b1;
            2:       op_state = 1'b0;
            default: op_state = ($urandom_range(0, 3) != 0);
         endcase
         if (addr != IDLE_A && op_state) handle_access();
         prev_stall = (addr != IDLE_A) && !op_state;
         prev_addr  = addr;
         prev_wd    = wr_data;
      end
   end

   task automatic wait_quiet(input int budget);
      int calm = 0;
      int n = 0;
      while (calm < 10 && n < budget) begin
         @(posedge clk); #2;
         n++;
         if (exp_q.size() == 0 && ir_mem == 16'h0000 && !force_low && addr == IDLE_A && !clear)
            calm++;
         else
            calm = 0;
      end
      check_output("quiet reached", calm >= 10, 1);
   endtask

   task automatic clear_logs();
      log_a.delete(); log_d.delete(); ev_irs.delete(); ev_sk.delete();
   endtask

   task automatic pin_access(input string name, input int i, input logic [10:0] a, input logic [15:0] d);
      check_output({name, " addr"}, log_a[i], a);
      if (a[10]) check_output({name, " data"}, log_d[i], d);
   endtask

   task automatic pin_event(input string name, input int i, input logic [7:0] irs, input logic [3:0] sk);
      check_output({name, " ir_state"}, ev_irs[i], irs);
      check_output({name, " socket"}, ev_sk[i], sk);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) sn_mem[i] = 8'h00;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;
      check_output("idle addr after reset", addr, IDLE_A);

      // IPCF common interrupt, also pins first-read latency
      op_mode = 1; clear_logs();
      apply_stimulus(8'h80, 0, 8'h00);
      @(posedge clk); #2;
      check_output("first read latency", addr, 11'h002);
      wait_quiet(500);
      check_output("ipcf accesses", log_a.size(), 2);
      pin_access("ipcf rd", 0, 11'h002, 16'h0);
      pin_access("ipcf wr", 1, 11'h402, 16'h8000);
      check_output("ipcf events", ev_irs.size(), 1);
      pin_event("ipcf ev", 0, 8'h80, 4'b0000);

      clear_logs();
      apply_stimulus(8'h00, 0, 8'h04);
      wait_quiet(500);
      pin_access("s0 rd", 1, 11'h206, 16'h0);
      pin_access("s0 wr", 2, 11'h606, 16'h0004);
      pin_event("s0 ev", 0, 8'h04, 4'b1000);

      clear_logs();
      apply_stimulus(8'h00, 3, 8'h10);
      wait_quiet(500);
      pin_access("s3 rd", 1, 11'h2C6, 16'h0);
      pin_access("s3 wr", 2, 11'h6C6, 16'h0010);
      pin_event("s3 ev", 0, 8'h10, 4'b1011);

      clear_logs();
      apply_stimulus(8'h00, 7, 8'h01);
      wait_quiet(500);
      pin_access("s7 rd", 1, 11'h3C6, 16'h0);
      pin_access("s7 wr", 2, 11'h7C6, 16'h0001);
      pin_event("s7 ev", 0, 8'h01, 4'b1111);

      // Multi-source with an initial forced stall, then random acceptance
      clear_logs(); op_mode = 2;
      apply_stimulus(8'h80, 0, 8'h02);
      apply_stimulus(8'h00, 2, 8'h08);
      repeat (6) @(posedge clk); #2;
      check_output("stalled read addr", addr, 11'h002);
      op_mode = 0;
      wait_quiet(1000);
      check_output("multi accesses", log_a.size(), 6);
      pin_access("multi wr ir", 1, 11'h402, 16'h8000);
      pin_access("multi rd s2", 4, 11'h286, 16'h0);
      pin_access("multi wr s2", 5, 11'h686, 16'h0008);
      check_output("multi events", ev_irs.size(), 3);
      pin_event("multi ev0", 0, 8'h80, 4'b0000);
      pin_event("multi ev1", 1, 8'h02, 4'b1000);
      pin_event("multi ev2", 2, 8'h08, 4'b1010);

      // Spurious interrupt: IR reads zero, no report
      clear_logs(); op_mode = 1;
      force_low = 1;
      wait_quiet(500);
      check_output("spurious accesses", log_a.size(), 1);
      check_output("spurious events", ev_irs.size(), 0);

      // Random traffic, first between passes, then with mid-pass arrivals
      op_mode = 0;
      for (int k = 0; k < 20; k++) begin
         apply_stimulus(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
                        $urandom_range(0, 7), 8'($urandom_range(0, 31)));
         if (ir_mem == 16'h0000) force_low = 1;
         wait_quiet(2000);
      end
      inject_en = 1;
      repeat (3000) @(posedge clk);
      inject_en = 0;
      wait_quiet(5000);

      // Reset during the socket-5 acknowledge write
      op_mode = 1;
      apply_stimulus(8'h00, 5, 8'h04);
      begin
         int n = 0;
         while (addr != {1'b1, sn_addr(5)} && n < 200) begin
            @(posedge clk); #2;
            n++;
         end
         check_output("reached WR_SN", addr, {1'b1, sn_addr(5)});
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      check_output("no ack during reset", sn_mem[5], 8'h04);
      #2 rst_n = 1'b1;
      wait_quiet(1000);
      check_output("serviced after reset", sn_mem[5], 8'h00);
      check_output("final queue empty", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
